// File: rtl/vc_egress_arbiter.sv
// Round-robin drain of four virtual-channel FIFOs into one egress FIFO with a fixed 2-cycle pop->push pipeline.
// Optional per-class grant counters are built when VC_ARB_STATS_EN is defined.
module vc_egress_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [3:0]            state,
  input  logic                  empty_0,
  input  logic                  empty_1,
  input  logic                  empty_2,
  input  logic                  empty_3,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic                  almost_full_out,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic                  push_out,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef VC_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt_0,
  output logic [15:0]           grant_cnt_1,
  output logic [15:0]           grant_cnt_2,
  output logic [15:0]           grant_cnt_3
`endif
);

  localparam int NCLS = 1 << PTR_W;

  logic                  st_init, st_active;
  logic [NCLS-1:0]       empty_v, eligible;
  logic [DATA_WIDTH-1:0] din [NCLS];

  logic [NCLS-1:0]       pop_q, pop_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      sel_q, sel_d, sel2_q;
  logic                  v1_q, v1_d, v2_q;
  logic                  push_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  grant;
  logic [PTR_W-1:0]      winner, idx;

  assign st_init   = (state == 4'b0001);
  assign st_active = (state == 4'b0100) || (state == 4'b1000);

  assign empty_v = {empty_3, empty_2, empty_1, empty_0};
  assign din[0]  = data_in_0;
  assign din[1]  = data_in_1;
  assign din[2]  = data_in_2;
  assign din[3]  = data_in_3;

  // A class popped last cycle may still show a stale non-empty flag.
  assign eligible = ~empty_v & ~pop_q;

  always_comb begin
    grant  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NCLS; k++) begin
      idx = ptr_q + PTR_W'(k);
      if (!grant && eligible[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    pop_d = '0;
    ptr_d = ptr_q;
    sel_d = sel_q;
    v1_d  = 1'b0;
    if (st_active && !almost_full_out && grant) begin
      pop_d[winner] = 1'b1;
      ptr_d         = winner + PTR_W'(1);
      sel_d         = winner;
      v1_d          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_q  <= '0;
      ptr_q  <= '0;
      sel_q  <= '0;
      sel2_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      push_q <= 1'b0;
      data_q <= '0;
    end else if (st_init) begin
      pop_q  <= '0;
      ptr_q  <= '0;
      sel_q  <= '0;
      sel2_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      push_q <= 1'b0;
      data_q <= '0;
    end else begin
      pop_q  <= pop_d;
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      v1_q   <= v1_d;
      v2_q   <= v1_q;
      sel2_q <= sel_q;
      push_q <= v2_q;
      if (v2_q) data_q <= din[sel2_q];
    end
  end

  assign {pop_3, pop_2, pop_1, pop_0} = pop_q;
  assign push_out = push_q;
  assign data_out = data_q;

`ifdef VC_ARB_STATS_EN
  logic [15:0] cnt [NCLS];

  for (genvar g = 0; g < NCLS; g++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)                           cnt_q <= '0;
      else if (st_init)                       cnt_q <= '0;
      else if (pop_d[g] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign cnt[g] = cnt_q;
  end

  assign grant_cnt_0 = cnt[0];
  assign grant_cnt_1 = cnt[1];
  assign grant_cnt_2 = cnt[2];
  assign grant_cnt_3 = cnt[3];
`endif

endmodule

// File: tb/tb_vc_egress_arbiter.sv
// Directed bench for vc_egress_arbiter: per-cycle expected pops/push/data tables plus reset, INIT and counter sequences.
module tb_vc_egress_arbiter;

  localparam logic [3:0] ACT  = 4'b0100;
  localparam logic [3:0] ACT2 = 4'b1000;
  localparam logic [3:0] IDL  = 4'b0000;
  localparam logic [3:0] INI  = 4'b0001;

  typedef struct {
    logic [3:0]  st;
    logic        af;
    logic [3:0]  pop;
    logic        push;
    logic [11:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [3:0]  st_r;
  logic [3:0]  empty;
  logic [11:0] din [4];
  logic        af;
  logic        pop_0, pop_1, pop_2, pop_3;
  logic [3:0]  pop;
  logic        push_out;
  logic [11:0] data_out;
`ifdef VC_ARB_STATS_EN
  logic [15:0] gc0, gc1, gc2, gc3;
`endif

  int checks   = 0;
  int failures = 0;

  logic [11:0] mem [4][32];
  int          rd [4];
  int          wr [4];
  vec_t        vq [$];

  always #5 clk = ~clk;
  assign pop = {pop_3, pop_2, pop_1, pop_0};

  vc_egress_arbiter #(.DATA_WIDTH(12), .PTR_W(2)) dut (
    .clk(clk), .reset_L(reset_L), .state(st_r),
    .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]), .empty_3(empty[3]),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .almost_full_out(af),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .push_out(push_out), .data_out(data_out)
`ifdef VC_ARB_STATS_EN
    , .grant_cnt_0(gc0), .grant_cnt_1(gc1), .grant_cnt_2(gc2), .grant_cnt_3(gc3)
`endif
  );

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic upd_empty();
    for (int i = 0; i < 4; i++) empty[i] = (rd[i] == wr[i]);
  endtask

  task automatic load(input int c, input logic [11:0] w);
    mem[c][wr[c] % 32] = w;
    wr[c]++;
    upd_empty();
  endtask

  // FIFO model: a pop seen this cycle presents the head word for the following cycle.
  task automatic model_pop();
    for (int i = 0; i < 4; i++)
      if (pop[i] && rd[i] != wr[i]) begin
        din[i] = mem[i][rd[i] % 32];
        rd[i]++;
      end
    upd_empty();
  endtask

  task automatic step();
    @(negedge clk);
    model_pop();
  endtask

  function automatic vec_t mk(input logic [3:0] s, input logic a, input logic [3:0] p,
                              input logic ps, input logic [11:0] d);
    vec_t v;
    v.st = s; v.af = a; v.pop = p; v.push = ps; v.data = d;
    return v;
  endfunction

  task automatic run_range(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      st_r = vq[k].st;
      af   = vq[k].af;
      @(negedge clk);
      check($sformatf("row%0d", k), {pop, push_out, data_out},
            {vq[k].pop, vq[k].push, vq[k].data});
      model_pop();
    end
  endtask

  initial begin
    int a_end, b_end, c0_end, c_end, d_end, e8_end, e_end, f_end;
    for (int i = 0; i < 4; i++) begin rd[i] = 0; wr[i] = 0; din[i] = '0; end
    empty = 4'hF; af = 1'b0; st_r = IDL; reset_L = 1'b0;

    // All-four round robin
    vq.push_back(mk(ACT, 0, 4'b0001, 0, 12'h000));
    vq.push_back(mk(ACT, 0, 4'b0010, 0, 12'h000));
    vq.push_back(mk(ACT, 0, 4'b0100, 1, 12'h0A1));
    vq.push_back(mk(ACT, 0, 4'b1000, 1, 12'h4A1));
    vq.push_back(mk(ACT, 0, 4'b0001, 1, 12'h8A1));
    vq.push_back(mk(ACT, 0, 4'b0010, 1, 12'hCA1));
    vq.push_back(mk(ACT, 0, 4'b0100, 1, 12'h0A2));
    vq.push_back(mk(ACT, 0, 4'b1000, 1, 12'h4A2));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'h8A2));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'hCA2));
    vq.push_back(mk(ACT, 0, 4'b0000, 0, 12'hCA2));
    a_end = vq.size();
    // Single class: 50% throughput
    vq.push_back(mk(ACT2, 0, 4'b0100, 0, 12'hCA2));
    vq.push_back(mk(ACT2, 0, 4'b0000, 0, 12'hCA2));
    vq.push_back(mk(ACT2, 0, 4'b0100, 1, 12'h8A1));
    vq.push_back(mk(ACT2, 0, 4'b0000, 0, 12'h8A1));
    vq.push_back(mk(ACT2, 0, 4'b0100, 1, 12'h8A2));
    vq.push_back(mk(ACT2, 0, 4'b0000, 0, 12'h8A2));
    vq.push_back(mk(ACT2, 0, 4'b0000, 1, 12'h8A3));
    vq.push_back(mk(ACT2, 0, 4'b0000, 0, 12'h8A3));
    b_end = vq.size();
    // Move ptr to 2, then classes 1 and 3 alternate starting at 3
    vq.push_back(mk(ACT, 0, 4'b0010, 0, 12'h8A3));
    c0_end = vq.size();
    vq.push_back(mk(ACT, 0, 4'b1000, 0, 12'h8A3));
    vq.push_back(mk(ACT, 0, 4'b0010, 1, 12'h4B0));
    vq.push_back(mk(ACT, 0, 4'b1000, 1, 12'hCB1));
    vq.push_back(mk(ACT, 0, 4'b0010, 1, 12'h4B1));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'hCB2));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'h4B2));
    vq.push_back(mk(ACT, 0, 4'b0000, 0, 12'h4B2));
    c_end = vq.size();
    // almost_full with two words in flight
    vq.push_back(mk(ACT, 0, 4'b0001, 0, 12'h4B2));
    vq.push_back(mk(ACT, 0, 4'b0010, 0, 12'h4B2));
    vq.push_back(mk(ACT, 1, 4'b0000, 1, 12'h0C1));
    vq.push_back(mk(ACT, 1, 4'b0000, 1, 12'h4C1));
    vq.push_back(mk(ACT, 1, 4'b0000, 0, 12'h4C1));
    vq.push_back(mk(ACT, 0, 4'b0001, 0, 12'h4C1));
    vq.push_back(mk(ACT, 0, 4'b0010, 0, 12'h4C1));
    vq.push_back(mk(ACT, 0, 4'b0001, 1, 12'h0C2));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'h4C2));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'h0C3));
    vq.push_back(mk(ACT, 0, 4'b0000, 0, 12'h0C3));
    d_end = vq.size();
    // IDLE lets in-flight complete; INIT drops in-flight and resets ptr
    vq.push_back(mk(ACT,  0, 4'b0100, 0, 12'h0C3));
    vq.push_back(mk(IDL,  0, 4'b0000, 0, 12'h0C3));
    vq.push_back(mk(IDL,  0, 4'b0000, 1, 12'h8D1));
    vq.push_back(mk(IDL,  0, 4'b0000, 0, 12'h8D1));
    vq.push_back(mk(4'b0010, 0, 4'b0000, 0, 12'h8D1));
    vq.push_back(mk(ACT2, 0, 4'b0100, 0, 12'h8D1));
    vq.push_back(mk(INI,  0, 4'b0000, 0, 12'h000));
    vq.push_back(mk(ACT,  0, 4'b0000, 0, 12'h000));
    e8_end = vq.size();
    vq.push_back(mk(ACT, 0, 4'b0001, 0, 12'h000));
    vq.push_back(mk(ACT, 0, 4'b1000, 0, 12'h000));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'h0E1));
    vq.push_back(mk(ACT, 0, 4'b0000, 1, 12'hCE1));
    e_end = vq.size();
    // Traffic before async reset
    vq.push_back(mk(ACT, 0, 4'b0010, 0, 12'hCE1));
    vq.push_back(mk(ACT, 0, 4'b0100, 0, 12'hCE1));
    vq.push_back(mk(ACT, 0, 4'b0010, 1, 12'h4F1));
    f_end = vq.size();

    #1;
    check("rst_pop", {13'd0, pop}, 17'd0);
    check("rst_push", {16'd0, push_out}, 17'd0);
    check("rst_data", {5'd0, data_out}, 17'd0);
    @(negedge clk);
    reset_L = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load(i, {i[1:0], 10'h0A1});
      load(i, {i[1:0], 10'h0A2});
    end
    run_range(0, a_end);

    load(2, 12'h8A1); load(2, 12'h8A2); load(2, 12'h8A3);
    run_range(a_end, b_end);

    load(1, 12'h4B0);
    run_range(b_end, c0_end);
    load(1, 12'h4B1); load(1, 12'h4B2); load(3, 12'hCB1); load(3, 12'hCB2);
    run_range(c0_end, c_end);

    load(0, 12'h0C1); load(0, 12'h0C2); load(0, 12'h0C3);
    load(1, 12'h4C1); load(1, 12'h4C2);
    run_range(c_end, d_end);

    load(2, 12'h8D1); load(2, 12'h8D2);
    run_range(d_end, e8_end);
    load(0, 12'h0E1); load(3, 12'hCE1);
    run_range(e8_end, e_end);

    load(1, 12'h4F1); load(1, 12'h4F2); load(2, 12'h8F1);
    run_range(e_end, f_end);

    #2 reset_L = 1'b0;
    #1;
    check("async_pop", {13'd0, pop}, 17'd0);
    check("async_push", {16'd0, push_out}, 17'd0);
    check("async_data", {5'd0, data_out}, 17'd0);
    step();
    check("rst_hold", {pop, push_out, data_out}, 17'd0);
    reset_L = 1'b1;
    st_r = ACT;
    step();
    check("post_rst", {pop, push_out, data_out}, 17'd0);

`ifdef VC_ARB_STATS_EN
    for (int n = 0; n < 5; n++) load(0, 12'h010 + 12'(n));
    for (int n = 0; n < 10; n++) step();
    check("cnt0_five", {1'b0, gc0}, 17'd5);
    check("cnt1_zero", {1'b0, gc1}, 17'd0);
    force dut.g_cnt[0].cnt_q = 16'hFFFE;
    #1;
    release dut.g_cnt[0].cnt_q;
    for (int n = 0; n < 3; n++) load(0, 12'h020 + 12'(n));
    for (int n = 0; n < 8; n++) step();
    check("cnt0_sat", {1'b0, gc0}, 17'h0FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_egress_arbiter.md
# vc_egress_arbiter

Round-robin arbiter draining the four per-class virtual-channel FIFOs (classes 0–3, filled by the class router) into the single egress FIFO of the transaction layer. Each cycle it selects at most one non-empty class FIFO, issues its pop, captures the returned word and pushes it downstream. It honours downstream `almost_full` and the layer's `state` word.

## Interface
- `DATA_WIDTH`, 12: word width. Bits [11:10] carry the class.
- `PTR_W`, 2: width of the round-robin pointer. Fixed for 4 classes.
- `clk` input 1: single clock, rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `state` input 4: layer state. `'b0001` = INIT; `'b0100`/`'b1000` = ACTIVE; anything else = IDLE.
- `empty_0..empty_3` input 1 each: class FIFO empty flags.
- `data_in_0..data_in_3` input DATA_WIDTH each: class FIFO read data. Valid the cycle after the pop cycle.
- `pop_0..pop_3` output 1 each: class FIFO pops. Registered; at most one high per cycle.
- `almost_full_out` input 1: egress FIFO almost-full.
- `push_out` output 1: egress FIFO push. Registered.
- `data_out` output DATA_WIDTH: egress write data. Registered; valid while `push_out` = 1.
- `grant_cnt_0..grant_cnt_3` output 16 each: per-class grant counters. Present only with `VC_ARB_STATS_EN`.

## Operation
- **Reset** (`reset_L` = 0, async):
  - All pops 0, `push_out` 0, `data_out` 0.
  - Pointer `ptr` = 0; pipeline valid bits cleared; counters 0.
- **INIT state**: synchronously clears the same registers as reset.
- **ACTIVE state**:
  - Class i is eligible when `empty_i` = 0 and i was not popped in the previous cycle. The previous-cycle exclusion guards against a stale `empty`.
  - Grant condition: `almost_full_out` = 0 and at least one class is eligible.
  - Winner = first eligible class scanning `ptr`, `ptr`+1, … modulo 4.
  - On a grant: `pop_winner` <= 1, all other pops <= 0, `ptr` <= winner + 1 (2-bit wrap, 3 -> 0), `sel_q` <= winner, `v1` <= 1.
  - No grant: all pops <= 0, `ptr` held, `v1` <= 0.
- **IDLE state**: no new pops; `ptr` held. Words already in flight still complete their push.
- **Pipeline**:
  - Stage 1: `v1`/`sel_q` mark the cycle in which the pop is asserted.
  - Stage 2: `v2`/`sel2` mark the following cycle, when `data_in_sel2` is valid.
  - While `v2` = 1 the block registers `data_out` <= `data_in_sel2` and `push_out` <= 1; otherwise `push_out` <= 0 and `data_out` holds.
- **Only one non-empty class**: that class alternates pop / no-pop, giving 50% throughput.
- **almost_full while words are in flight**: in-flight words are still pushed. The egress FIFO almost-full threshold must leave at least 2 free entries.
- **Simultaneous INIT and in-flight words**: INIT wins and the in-flight words are dropped.

## Timing
- Pop asserted in cycle c -> `data_in` valid in c+1 -> `push_out`/`data_out` valid in c+2. Fixed 2-cycle latency.
- Peak throughput: 1 word/cycle when at least 2 classes are non-empty.
- `almost_full_out` sampled at edge E: no pop is asserted in the cycle after E.
- Asynchronous reset assertion clears outputs immediately; deassertion takes effect at the next `clk` edge.

## Configuration
- `VC_ARB_STATS_EN` defined:
  - `grant_cnt_i` ports exist.
  - Each counter increments by 1 on every grant to class i and saturates at 16'hFFFF.
  - Cleared by reset and by INIT.
- `VC_ARB_STATS_EN` undefined: the ports and the counters are absent. All other behaviour is identical.

## Test plan
- **Reset/INIT**: `reset_L` low mid-traffic -> all pops 0, `push_out` 0, `data_out` 0 immediately. INIT for 1 cycle -> same state at the next edge.
- **All four full, ACTIVE, `almost_full_out` = 0**: pops in order 0,1,2,3,0 on consecutive cycles. `push_out` is high from cycle 3 onward; `data_out` class bits follow 0,1,2,3.
- **Only class 2 non-empty with 3 words (12'h8A1, 12'h8A2, 12'h8A3)**: `pop_2` pattern 1,0,1,0,1. `data_out` = 8A1, 8A2, 8A3, each 2 cycles after its pop.
- **Classes 1 and 3 non-empty, `ptr` = 2**: first grant goes to 3, then 1, then 3, alternating.
- **`almost_full_out` rises while 2 words are in flight**: no further pops, both in-flight words are still pushed, then `push_out` = 0. Popping resumes one cycle after `almost_full_out` falls.
- **STATS build**: 5 grants to class 0 -> `grant_cnt_0` = 5. Preload `grant_cnt_0` = 16'hFFFE, then 3 grants -> `grant_cnt_0` = 16'hFFFF.
